// File: rtl/seq_mult4_ctrl.sv
// Shift-and-add N x N unsigned multiplier controller driving one shared external N-bit adder.
// Each RUN cycle adds M (or 0) to A via the adder and shifts {carry, sum, Q} right by one.
module seq_mult4_ctrl #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [N-1:0]   add_x,
   output logic [N-1:0]   add_y,
   output logic           add_ci,
   input  logic [N-1:0]   add_s,
   input  logic           add_co,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] p
);

   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [N-1:0]  acc;
   logic [N-1:0]  q;
   logic [N-1:0]  m;
   logic [CW-1:0] cnt;
   logic          last_step;

   assign last_step = (cnt == CW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_RUN;
         S_RUN:   if (last_step) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state == S_RUN);
      done   = (state == S_DONE);
      add_x  = acc;
      add_y  = q[0] ? m : '0;
      add_ci = 1'b0;
   end

   // The adder carry becomes the new MSB of A; the final step's shifted value is the product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         q   <= '0;
         m   <= '0;
         cnt <= '0;
         p   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  m   <= a;
                  q   <= b;
                  acc <= '0;
                  cnt <= '0;
               end
            end
            S_RUN: begin
               {acc, q} <= {add_co, add_s, q[N-1:1]};
               cnt      <= cnt + CW'(1);
               if (last_step) begin
                  p <= {add_co, add_s, q[N-1:1]};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult4_ctrl.sv
// Bench for seq_mult4_ctrl: supplies the external adder and checks handshake timing,
// per-step adder operands against an independent shift-and-add model, and products.
module tb_seq_mult4_ctrl;

   localparam int N = 4;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic [N-1:0]   add_x;
   logic [N-1:0]   add_y;
   logic           add_ci;
   logic [N-1:0]   add_s;
   logic           add_co;
   logic           busy;
   logic           done;
   logic [2*N-1:0] p;

   int total = 0;
   int bad   = 0;
   logic [2*N-1:0] last_p;

   seq_mult4_ctrl #(.N(N)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .add_x  (add_x),
      .add_y  (add_y),
      .add_ci (add_ci),
      .add_s  (add_s),
      .add_co (add_co),
      .busy   (busy),
      .done   (done),
      .p      (p)
   );

   assign {add_co, add_s} = {1'b0, add_x} + {1'b0, add_y} + {4'b0000, add_ci};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]   va;
      logic [N-1:0]   vb;
      logic [2*N-1:0] vp;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One full operation starting from IDLE, with a step-by-step reference model.
   task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic [2*N-1:0] exp_p);
      logic [N-1:0] ma, mq, mm, my;
      logic [N:0]   t;
      @(negedge clk);
      start = 1'b1;
      a     = ta;
      b     = tb_;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("p_held_on_accept", 32'(p), 32'(last_p));
      ma = '0;
      mq = tb_;
      mm = ta;
      for (int s = 0; s < N; s++) begin
         @(negedge clk);
         my = mq[0] ? mm : 4'd0;
         chk("add_x", 32'(add_x), 32'(ma));
         chk("add_y", 32'(add_y), 32'(my));
         chk("add_ci", 32'(add_ci), 32'd0);
         chk("done_in_run", 32'(done), 32'd0);
         t = {1'b0, ma} + {1'b0, my};
         {ma, mq} = {t, mq[N-1:1]};
         @(posedge clk);
         #1;
         if (s < N - 1) chk("busy_run", 32'(busy), 32'd1);
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_in_done", 32'(busy), 32'd0);
      chk("product", 32'(p), 32'(exp_p));
      chk("model_product", 32'(p), 32'({ma, mq}));
      @(posedge clk);
      #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      last_p = exp_p;
   endtask

   vec_t vecs[10];
   int   dcount;

   initial begin
      vecs[0] = '{4'd13, 4'd11, 8'h8F};
      vecs[1] = '{4'd15, 4'd15, 8'hE1};
      vecs[2] = '{4'd0,  4'd9,  8'h00};
      vecs[3] = '{4'd9,  4'd0,  8'h00};
      vecs[4] = '{4'd9,  4'd6,  8'h36};
      vecs[5] = '{4'd7,  4'd5,  8'h23};
      vecs[6] = '{4'd2,  4'd3,  8'h06};
      vecs[7] = '{4'd1,  4'd1,  8'h01};
      vecs[8] = '{4'd15, 4'd1,  8'h0F};
      vecs[9] = '{4'd8,  4'd8,  8'h40};

      rst_n  = 1'b0;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      last_p = '0;
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_p", 32'(p), 32'd0);
      chk("reset_add_x", 32'(add_x), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].va, vecs[i].vb, vecs[i].vp);
      end

      // Starts during RUN and DONE are ignored; operand changes after acceptance have no effect.
      @(negedge clk);
      start = 1'b1;
      a     = 4'd9;
      b     = 4'd6;
      @(posedge clk);
      #1;
      start  = 1'b0;
      a      = 4'd3;
      b      = 4'd3;
      dcount = 0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 2) start = 1'b1;
         if (k == 3) begin
            start = 1'b0;
            a     = 4'd15;
            b     = 4'd15;
         end
         if (k == 5) begin
            start = 1'b1;
            a     = 4'd3;
            b     = 4'd3;
         end
         if (k == 6) start = 1'b0;
         @(posedge clk);
         #1;
         if (done) dcount++;
         if (k <= 3) chk("ign_busy_run", 32'(busy), 32'd1);
         if (k == 4) chk("ign_done", 32'(done), 32'd1);
         if (k >= 4) chk("ign_p", 32'(p), 32'h36);
         if (k >= 5) chk("ign_busy_idle", 32'(busy), 32'd0);
      end
      chk("ign_done_count", 32'(dcount), 32'd1);
      last_p = 8'h36;

      // start held high: a new operation every 6 cycles.
      @(negedge clk);
      start = 1'b1;
      a     = 4'd2;
      b     = 4'd3;
      for (int k = 0; k < 18; k++) begin
         @(posedge clk);
         #1;
         chk("b2b_busy", 32'(busy), 32'((k % 6) < 4));
         chk("b2b_done", 32'(done), 32'((k % 6) == 4));
         if ((k % 6) == 4) chk("b2b_p", 32'(p), 32'h06);
      end
      start  = 1'b0;
      last_p = 8'h06;

      // Asynchronous reset mid-RUN.
      @(negedge clk);
      start = 1'b1;
      a     = 4'd7;
      b     = 4'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_abort_busy", 32'(busy), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_p", 32'(p), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         chk("abort_no_done", 32'(done), 32'd0);
      end
      @(negedge clk);
      rst_n  = 1'b1;
      last_p = '0;
      @(posedge clk);
      #1;
      chk("post_abort_done", 32'(done), 32'd0);
      do_op(4'd7, 4'd5, 8'h23);

      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            do_op(4'(ia), 4'(ib), 8'(ia * ib));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
